axis_rgb_packer: RTL and testbench

AXIS_RGB_PACKER -- requirements
Module: axis_rgb_packer

---
 rtl/axis_rgb_packer.sv | 209 ++++++++++++++++++++
 tb/tb_axis_rgb_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rgb_packer.sv
// AXI-Stream packer: 24-bit RGB pixels in, BMP-order BGR bytes out, 4 pixels per 3 words.
// Define PACKER_SKID_EN for a 2-entry output skid buffer with a registered S_AXIS_TREADY.
module axis_rgb_packer #(
    parameter int unsigned FRAME_PIXELS = 262144
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        enable,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        frame_done,
    output logic [23:0] pixel_count
);

    localparam logic [2:0] PH0   = 3'd0;
    localparam logic [2:0] PH1   = 3'd1;
    localparam logic [2:0] PH2   = 3'd2;
    localparam logic [2:0] PH3   = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    localparam logic [23:0] LAST_IDX = 24'(FRAME_PIXELS - 1);
    localparam logic [23:0] CNT_MAX  = 24'hFF_FFFF;

    logic [2:0]  state_q, state_d;
    logic [23:0] residue_q, residue_d;
    logic [23:0] count_q, count_d;

    logic        s_accept;
    logic        eof;
    logic        out_room;
    logic        m_pop;
    logic        word_push;
    logic        word_last;
    logic [31:0] word_data;

    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA[31:24];

    assign s_accept    = S_AXIS_TVALID & S_AXIS_TREADY;
    assign eof         = S_AXIS_TLAST | (count_q == LAST_IDX);
    assign m_pop       = M_AXIS_TVALID & M_AXIS_TREADY;
    assign frame_done  = m_pop & M_AXIS_TLAST;
    assign pixel_count = count_q;

    // Residue is kept right-aligned with zero upper bytes, so a flush word is just {0, residue}.
    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        count_d   = count_q;
        word_push = 1'b0;
        word_last = 1'b0;
        word_data = '0;
        if (s_accept) begin
            if (eof) begin
                count_d = '0;
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + 24'd1;
            end
            unique case (state_q)
                PH0: begin
                    residue_d = S_AXIS_TDATA[23:0];
                    state_d   = eof ? FLUSH : PH1;
                end
                PH1: begin
                    word_push = 1'b1;
                    word_data = {S_AXIS_TDATA[7:0], residue_q};
                    residue_d = {8'h00, S_AXIS_TDATA[23:8]};
                    state_d   = eof ? FLUSH : PH2;
                end
                PH2: begin
                    word_push = 1'b1;
                    word_data = {S_AXIS_TDATA[15:0], residue_q[15:0]};
                    residue_d = {16'h0000, S_AXIS_TDATA[23:16]};
                    state_d   = eof ? FLUSH : PH3;
                end
                PH3: begin
                    word_push = 1'b1;
                    word_data = {S_AXIS_TDATA[23:0], residue_q[7:0]};
                    word_last = eof;
                    residue_d = '0;
                    state_d   = PH0;
                end
                default: ;
            endcase
        end else if ((state_q == FLUSH) && enable && out_room) begin
            word_push = 1'b1;
            word_data = {8'h00, residue_q};
            word_last = 1'b1;
            residue_d = '0;
            state_d   = PH0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= PH0;
            residue_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            count_q   <= count_d;
        end
    end

`ifdef PACKER_SKID_EN
    // Two-entry FIFO; head drives the M_AXIS outputs and only changes on a pop.
    logic [1:0]  fill_q, fill_d;
    logic [32:0] head_q, head_d;
    logic [32:0] tail_q, tail_d;
    logic [32:0] push_word;
    logic        s_ready_q, s_ready_d;

    assign push_word     = {word_last, word_data};
    assign out_room      = (fill_q != 2'd2) | M_AXIS_TREADY;
    assign M_AXIS_TVALID = (fill_q != 2'd0);
    assign M_AXIS_TDATA  = head_q[31:0];
    assign M_AXIS_TLAST  = head_q[32];
    assign S_AXIS_TREADY = s_ready_q & enable & ~ARESET;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        case ({word_push, m_pop})
            2'b10: begin
                if (fill_q == 2'd0) begin
                    head_d = push_word;
                end else begin
                    tail_d = push_word;
                end
                fill_d = fill_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                fill_d = fill_q - 2'd1;
            end
            2'b11: begin
                if (fill_q == 2'd1) begin
                    head_d = push_word;
                end else begin
                    head_d = tail_q;
                    tail_d = push_word;
                end
            end
            default: ;
        endcase
        // Ready only when a push next cycle fits even without a pop.
        s_ready_d = (state_d != FLUSH) && (fill_d != 2'd2);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            fill_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            s_ready_q <= 1'b1;
        end else begin
            fill_q    <= fill_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            s_ready_q <= s_ready_d;
        end
    end
`else
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;

    assign out_room      = ~valid_q | M_AXIS_TREADY;
    assign M_AXIS_TVALID = valid_q;
    assign M_AXIS_TDATA  = data_q;
    assign M_AXIS_TLAST  = last_q;
    assign S_AXIS_TREADY = ~ARESET & enable & (state_q != FLUSH) & out_room;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (word_push) begin
            valid_d = 1'b1;
            last_d  = word_last;
            data_d  = word_data;
        end else if (m_pop) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end
`endif

endmodule

// File: tb/tb_axis_rgb_packer.sv
// Self-checking bench for axis_rgb_packer: directed vector table, hand sequences, random traffic
// checked against a byte-stream reference model.
module tb_axis_rgb_packer;

    localparam int unsigned FP = 5;
    localparam int NV = 14;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TLAST = 1'b0;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY = 1'b1;
    logic        frame_done;
    logic [23:0] pixel_count;

    always #5 ACLK = ~ACLK;

    axis_rgb_packer #(.FRAME_PIXELS(FP)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .enable        (enable),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .frame_done    (frame_done),
        .pixel_count   (pixel_count)
    );

    typedef struct {
        logic        s_valid;
        logic [31:0] s_data;
        logic        s_last;
        logic        e_s_ready;
        logic        e_m_valid;
        logic [31:0] e_m_data;
        logic        e_m_last;
        logic        e_done;
        logic [23:0] e_count;
    } vec_t;

    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the current frame in BMP order, and words still owed.
    logic [7:0]  frame_bytes[$];
    logic [32:0] exp_q[$];
    int          model_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l,
                                input logic er, input logic emv, input logic [31:0] emd,
                                input logic eml, input logic efd, input logic [23:0] ec);
        vec_t r;
        r.s_valid   = v;
        r.s_data    = d;
        r.s_last    = l;
        r.e_s_ready = er;
        r.e_m_valid = emv;
        r.e_m_data  = emd;
        r.e_m_last  = eml;
        r.e_done    = efd;
        r.e_count   = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_bytes.delete();
        exp_q.delete();
        model_cnt  = 0;
        prev_stall = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] px, input logic last);
        logic        eof;
        logic [32:0] w;
        frame_bytes.push_back(px[7:0]);
        frame_bytes.push_back(px[15:8]);
        frame_bytes.push_back(px[23:16]);
        model_cnt++;
        eof = last || (model_cnt == int'(FP));
        if (eof) begin
            while ((frame_bytes.size() % 4) != 0) frame_bytes.push_back(8'h00);
            model_cnt = 0;
        end
        while (frame_bytes.size() >= 4) begin
            w[31:0] = {frame_bytes[3], frame_bytes[2], frame_bytes[1], frame_bytes[0]};
            for (int k = 0; k < 4; k++) frame_bytes.delete(0);
            w[32] = eof && (frame_bytes.size() == 0);
            exp_q.push_back(w);
        end
    endtask

    // Called a few ns before the rising edge: inspects what that edge will transfer.
    task automatic monitor();
        logic [32:0] w;
        if (ARESET) begin
            check("s_ready_in_reset", 64'(S_AXIS_TREADY), 64'd0);
            model_reset();
        end else begin
            check("pixel_count", 64'(pixel_count), 64'(model_cnt));
            if (!enable) check("s_ready_disabled", 64'(S_AXIS_TREADY), 64'd0);
            if (prev_stall) begin
                check("stall_valid", 64'(M_AXIS_TVALID), 64'd1);
                check("stall_hold", 64'({M_AXIS_TLAST, M_AXIS_TDATA}), 64'(prev_word));
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h last %0b, expected no word at %0t",
                             M_AXIS_TDATA, M_AXIS_TLAST, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("m_word", 64'({M_AXIS_TLAST, M_AXIS_TDATA}), 64'(w));
                    check("frame_done", 64'(frame_done), 64'(w[32]));
                end
            end else begin
                check("frame_done_idle", 64'(frame_done), 64'd0);
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_word  = {M_AXIS_TLAST, M_AXIS_TDATA};
            if (S_AXIS_TVALID && S_AXIS_TREADY) model_accept(S_AXIS_TDATA, S_AXIS_TLAST);
        end
    endtask

    task automatic tick();
        #2;
        monitor();
        @(negedge ACLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then frames of 4 (TLAST), 5 (count EOF, 3-byte flush), 2 (TLAST, flush).
        vecs[0]  = mk(1'b1, 32'h00112233, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 24'd0);
        vecs[1]  = mk(1'b1, 32'h00445566, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 24'd1);
        vecs[2]  = mk(1'b1, 32'h00778899, 1'b0, 1'b1, 1'b1, 32'h66112233, 1'b0, 1'b0, 24'd2);
        vecs[3]  = mk(1'b1, 32'h00AABBCC, 1'b1, 1'b1, 1'b1, 32'h88994455, 1'b0, 1'b0, 24'd3);
        vecs[4]  = mk(1'b1, 32'h00112233, 1'b0, 1'b1, 1'b1, 32'hAABBCC77, 1'b1, 1'b1, 24'd0);
        vecs[5]  = mk(1'b1, 32'h00445566, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 24'd1);
        vecs[6]  = mk(1'b1, 32'h00778899, 1'b0, 1'b1, 1'b1, 32'h66112233, 1'b0, 1'b0, 24'd2);
        vecs[7]  = mk(1'b1, 32'h00AABBCC, 1'b0, 1'b1, 1'b1, 32'h88994455, 1'b0, 1'b0, 24'd3);
        vecs[8]  = mk(1'b1, 32'h00DDEEFF, 1'b0, 1'b1, 1'b1, 32'hAABBCC77, 1'b0, 1'b0, 24'd4);
        vecs[9]  = mk(1'b1, 32'h00010203, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'd0);
        vecs[10] = mk(1'b1, 32'h00010203, 1'b0, 1'b1, 1'b1, 32'h00DDEEFF, 1'b1, 1'b1, 24'd0);
        vecs[11] = mk(1'b1, 32'hFF040506, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 24'd1);
        vecs[12] = mk(1'b1, 32'h000A0B0C, 1'b0, 1'b0, 1'b1, 32'h06010203, 1'b0, 1'b0, 24'd0);
        vecs[13] = mk(1'b1, 32'h000A0B0C, 1'b0, 1'b1, 1'b1, 32'h00000405, 1'b1, 1'b1, 24'd0);

        @(negedge ACLK);
        tick();
        #1;
        check("rst_m_valid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_m_last", 64'(M_AXIS_TLAST), 64'd0);
        check("rst_m_data", 64'(M_AXIS_TDATA), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_pixel_count", 64'(pixel_count), 64'd0);
        check("rst_s_ready", 64'(S_AXIS_TREADY), 64'd0);
        ARESET = 1'b0;

        for (int i = 0; i < NV; i++) begin
            S_AXIS_TVALID = vecs[i].s_valid;
            S_AXIS_TDATA  = vecs[i].s_data;
            S_AXIS_TLAST  = vecs[i].s_last;
            #2;
            check($sformatf("vec%0d_s_ready", i), 64'(S_AXIS_TREADY), 64'(vecs[i].e_s_ready));
            check($sformatf("vec%0d_m_valid", i), 64'(M_AXIS_TVALID), 64'(vecs[i].e_m_valid));
            if (vecs[i].e_m_valid) begin
                check($sformatf("vec%0d_m_data", i), 64'(M_AXIS_TDATA), 64'(vecs[i].e_m_data));
                check($sformatf("vec%0d_m_last", i), 64'(M_AXIS_TLAST), 64'(vecs[i].e_m_last));
            end
            check($sformatf("vec%0d_done", i), 64'(frame_done), 64'(vecs[i].e_done));
            check($sformatf("vec%0d_count", i), 64'(pixel_count), 64'(vecs[i].e_count));
            monitor();
            @(negedge ACLK);
        end

        // Reset mid-frame with words held: nothing from the old frame may come out.
        M_AXIS_TREADY = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TLAST  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S_AXIS_TDATA = 32'h00C0C0C0 + 32'(i);
            tick();
        end
        ARESET = 1'b1;
        S_AXIS_TVALID = 1'b0;
        tick();
        ARESET = 1'b0;
        M_AXIS_TREADY = 1'b1;
        #1;
        check("post_rst_s_ready", 64'(S_AXIS_TREADY), 64'd1);
        check("post_rst_m_valid", 64'(M_AXIS_TVALID), 64'd0);
        check("post_rst_count", 64'(pixel_count), 64'd0);
        for (int i = 0; i < 4; i++) tick();

        // Enable dropped mid-frame freezes the frame; it resumes afterwards.
        S_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            S_AXIS_TDATA = 32'h00102030 + 32'(i);
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("frozen_count", 64'(pixel_count), 64'd2);
        enable = 1'b1;
        S_AXIS_TDATA = 32'h00405060;
        S_AXIS_TLAST = 1'b1;
        tick();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with stalls, enable drops and early TLAST.
        for (int c = 0; c < 4000; c++) begin
            enable        = ($urandom_range(0, 9) != 0);
            S_AXIS_TVALID = ($urandom_range(0, 9) < 7);
            S_AXIS_TDATA  = $urandom();
            S_AXIS_TLAST  = ($urandom_range(0, 15) == 0);
            M_AXIS_TREADY = ($urandom_range(0, 1) == 1);
            tick();
        end
        enable        = 1'b1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
